// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: instruction bit map,
// idle instruction word and sequencer state encoding.
package core_pkg;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int ADDR_W = 11;
    localparam int INST_W = 33;

    localparam int CEN_PMEM   = 32;
    localparam int WEN_PMEM   = 31;
    localparam int A_PMEM_LSB = 20;
    localparam int CEN_XMEM   = 19;
    localparam int WEN_XMEM   = 18;
    localparam int A_XMEM_LSB = 7;
    localparam int ACC        = 6;
    localparam int OFIFO_RD   = 5;
    localparam int L0_RD      = 4;
    localparam int L0_WR      = 3;
    localparam int EXECUTE    = 2;
    localparam int LOAD       = 1;
    localparam int SFP_EN     = 0;

    localparam logic [INST_W-1:0] IDLE_INST = 33'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE,
        W_LOAD,
        W_PROP,
        W_GAP,
        A_LOAD,
        EXEC,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Base-plus-offset SRAM address generator; the sum wraps modulo 2^ADDR_W.
module seq_addr_gen
    import core_pkg::*;
(
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] addr
);

    assign addr = base + offset;

endmodule

// File: rtl/inst_sequencer.sv
// Tile sequencer producing the registered 33-bit core instruction word.
// Optional abort input is enabled by defining INST_SEQ_ABORT_EN.
//
// state  | meaning
// IDLE   | waiting for start; inst = IDLE_INST
// W_LOAD | read col weight words from xmem into L0 (col+1 cycles)
// W_PROP | push weights from L0 into the PE array (col cycles)
// W_GAP  | let weights settle through the array (row cycles)
// A_LOAD | read n_act activation words into L0 (n_act+1 cycles)
// EXEC   | stream activations through the array (n_act cycles)
// DRAIN  | read OFIFO rows and write them to pmem one cycle later
// DONE   | single-cycle done pulse
module inst_sequencer
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] act_base,
    input  logic [ADDR_W-1:0] psum_base,
    input  logic [ADDR_W-1:0] n_act,
    input  logic              ofifo_valid,
`ifdef INST_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    seq_state_t        state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [ADDR_W-1:0] rd_cnt, rd_cnt_d;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_d;
    logic [ADDR_W-1:0] w_base_q, act_base_q, psum_base_q, n_act_q;
    logic [ADDR_W-1:0] xmem_base, ld_len, xmem_addr, pmem_addr;
    logic [INST_W-1:0] inst_d;
    logic              rd_fire;
    logic              abort_req;

`ifdef INST_SEQ_ABORT_EN
    assign abort_req = abort && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + ADDR_W'(1);
        rd_cnt_d = rd_cnt;
        wr_cnt_d = wr_cnt;
        rd_fire  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = (n_act != '0) ? W_LOAD : DONE;
            end
            W_LOAD: if (cnt == ADDR_W'(COL))     state_d = W_PROP;
            W_PROP: if (cnt == ADDR_W'(COL - 1)) state_d = W_GAP;
            W_GAP:  if (cnt == ADDR_W'(ROW - 1)) state_d = A_LOAD;
            A_LOAD: if (cnt == n_act_q)          state_d = EXEC;
            EXEC:   if (cnt == n_act_q - ADDR_W'(1)) state_d = DRAIN;
            DRAIN: begin
                cnt_d   = '0;
                rd_fire = ofifo_valid && (rd_cnt != n_act_q);
                if (rd_fire) rd_cnt_d = rd_cnt + ADDR_W'(1);
                // the current cycle is a pmem write when CEN_pmem is low
                if (!inst[CEN_PMEM]) begin
                    wr_cnt_d = wr_cnt + ADDR_W'(1);
                    if (wr_cnt == n_act_q - ADDR_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_req) state_d = IDLE;
        if (state_d != state) cnt_d = '0;
        if (state_d != DRAIN) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            rd_fire  = 1'b0;
        end
    end

    // bases are taken straight from the inputs on the start edge, latched copies afterwards
    assign xmem_base = (state_d == W_LOAD) ? ((state == IDLE) ? w_base : w_base_q) : act_base_q;
    assign ld_len    = (state_d == W_LOAD) ? ADDR_W'(COL) : n_act_q;

    seq_addr_gen u_xmem_addr (.base(xmem_base),   .offset(cnt_d),    .addr(xmem_addr));
    seq_addr_gen u_pmem_addr (.base(psum_base_q), .offset(wr_cnt_d), .addr(pmem_addr));

    always_comb begin
        inst_d      = IDLE_INST;
        inst_d[ACC] = 1'b0;
        case (state_d)
            W_LOAD, A_LOAD: begin
                if (cnt_d < ld_len) begin
                    inst_d[CEN_XMEM]                = 1'b0;
                    inst_d[WEN_XMEM]                = 1'b1;
                    inst_d[A_XMEM_LSB +: ADDR_W]    = xmem_addr;
                end
                if (cnt_d != '0) inst_d[L0_WR] = 1'b1;
            end
            W_PROP: begin
                inst_d[LOAD]  = 1'b1;
                inst_d[L0_RD] = 1'b1;
            end
            EXEC: begin
                inst_d[EXECUTE] = 1'b1;
                inst_d[L0_RD]   = 1'b1;
            end
            DRAIN: begin
                inst_d[OFIFO_RD] = rd_fire;
                if (inst[OFIFO_RD]) begin
                    inst_d[CEN_PMEM]             = 1'b0;
                    inst_d[WEN_PMEM]             = 1'b0;
                    inst_d[A_PMEM_LSB +: ADDR_W] = pmem_addr;
                    inst_d[SFP_EN]               = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            w_base_q    <= '0;
            act_base_q  <= '0;
            psum_base_q <= '0;
            n_act_q     <= '0;
            inst        <= IDLE_INST;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            rd_cnt <= rd_cnt_d;
            wr_cnt <= wr_cnt_d;
            inst   <= inst_d;
            busy   <= (state_d != IDLE);
            done   <= (state_d == DONE);
            if (state == IDLE && start) begin
                w_base_q    <= w_base;
                act_base_q  <= act_base;
                psum_base_q <= psum_base;
                n_act_q     <= n_act;
            end
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: a per-phase tile model fills a queue of
// expected {done, inst} words and a monitor pops one per busy/done cycle.
module tb_inst_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [32:0] IDLE_W = 33'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] w_base, act_base, psum_base, n_act;
    logic        ofifo_valid;
    logic [32:0] inst;
    logic        busy, done;
`ifdef INST_SEQ_ABORT_EN
    logic        abort;
`endif

    always #5 clk = ~clk;

    inst_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_base     (w_base),
        .act_base   (act_base),
        .psum_base  (psum_base),
        .n_act      (n_act),
        .ofifo_valid(ofifo_valid),
`ifdef INST_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    int          checks = 0;
    int          errors = 0;
    int          pop_idx = 0;
    bit          mon_en = 1'b0;
    logic [33:0] exp_q[$];
    logic        vv[0:1023];

    // Expected tile, phase by phase, from the documented phase lengths.
    task automatic build_model(input int wb, input int ab, input int pb, input int n, output int len);
        logic [32:0] w;
        int d, reads, writes, i;
        bit pend, rd_now, wr_now;
        len = 0;
        if (n == 0) begin
            exp_q.push_back({1'b1, IDLE_W});
            len = 1;
            return;
        end
        for (int k = 0; k <= COL; k++) begin
            w = IDLE_W;
            if (k < COL) begin w[19] = 1'b0; w[17:7] = 11'((wb + k) % 2048); end
            if (k >= 1) w[3] = 1'b1;
            exp_q.push_back({1'b0, w}); len++;
        end
        for (int k = 0; k < COL; k++) begin
            w = IDLE_W; w[1] = 1'b1; w[4] = 1'b1;
            exp_q.push_back({1'b0, w}); len++;
        end
        for (int k = 0; k < ROW; k++) begin
            exp_q.push_back({1'b0, IDLE_W}); len++;
        end
        for (int k = 0; k <= n; k++) begin
            w = IDLE_W;
            if (k < n) begin w[19] = 1'b0; w[17:7] = 11'((ab + k) % 2048); end
            if (k >= 1) w[3] = 1'b1;
            exp_q.push_back({1'b0, w}); len++;
        end
        for (int k = 0; k < n; k++) begin
            w = IDLE_W; w[2] = 1'b1; w[4] = 1'b1;
            exp_q.push_back({1'b0, w}); len++;
        end
        d = len; reads = 0; writes = 0; pend = 1'b0; i = 0;
        while (writes < n) begin
            w = IDLE_W;
            wr_now = pend;
            rd_now = (i > 0) && vv[d + i - 1] && (reads < n);
            if (wr_now) begin
                w[32] = 1'b0; w[31] = 1'b0;
                w[30:20] = 11'((pb + writes) % 2048);
                w[0] = 1'b1;
                writes++;
            end
            if (rd_now) begin w[5] = 1'b1; reads++; end
            pend = rd_now;
            exp_q.push_back({1'b0, w}); len++;
            i++;
        end
        exp_q.push_back({1'b1, IDLE_W}); len++;
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (busy || done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got inst=%h busy=%b done=%b want idle", inst, busy, done);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    if ({done, inst} !== e) begin
                        errors++;
                        $display("FAIL inst_word idx=%0d got inst=%h done=%b want inst=%h done=%b",
                                 pop_idx, inst, done, e[32:0], e[33]);
                    end
                    pop_idx++;
                end
            end else begin
                checks++;
                if (inst !== IDLE_W) begin
                    errors++;
                    $display("FAIL idle_inst got %h want %h", inst, IDLE_W);
                end
            end
        end
    end

    // mode 0: ofifo_valid always 1; 1: drain pattern 1,0,0,1,1,1; 2: random
    task automatic run_tile(input int wb, input int ab, input int pb, input int n, input int mode, input bit spur);
        int len, d;
        d = 2 * COL + ROW + 2 * n + 2;
        for (int c = 0; c < 1024; c++) begin
            if (mode == 0) vv[c] = 1'b1;
            else if (c >= d + 64) vv[c] = 1'b1;
            else vv[c] = 1'($urandom_range(0, 1));
        end
        if (mode == 1) begin
            for (int c = d; c < d + 64; c++) vv[c] = 1'b0;
            vv[d] = 1'b1; vv[d + 3] = 1'b1; vv[d + 4] = 1'b1; vv[d + 5] = 1'b1;
        end
        build_model(wb, ab, pb, n, len);
        @(posedge clk); #1;
        start = 1'b1; w_base = 11'(wb); act_base = 11'(ab); psum_base = 11'(pb); n_act = 11'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < len; c++) begin
            ofifo_valid = vv[c];
            if (spur && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                w_base = 11'($urandom); act_base = 11'($urandom);
                psum_base = 11'($urandom); n_act = 11'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL tile_end got busy=%b left=%0d want busy=0 left=0", busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        w_base = '0; act_base = '0; psum_base = '0; n_act = '0;
`ifdef INST_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12 reset = 1'b0;
        #3;
        checks++; if (inst !== IDLE_W) begin errors++; $display("FAIL reset_inst got %h want %h", inst, IDLE_W); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        mon_en = 1'b1;

        run_tile(11'h010, 11'h123, 11'h040, 4, 0, 1'b0);
        run_tile(11'h3A0, 11'h7FE, 11'h7FD, 4, 0, 1'b0);
        run_tile(11'h000, 11'h200, 11'h300, 4, 1, 1'b0);
        run_tile(11'h055, 11'h066, 11'h077, 0, 2, 1'b0);
        run_tile(11'h101, 11'h202, 11'h303, 5, 2, 1'b1);

        // asynchronous reset in the middle of EXEC
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; w_base = 11'h010; act_base = 11'h020; psum_base = 11'h030; n_act = 11'd4;
        @(posedge clk); #1;
        start = 1'b0; ofifo_valid = 1'b1;
        repeat (31) @(posedge clk);
        #2;
        checks++; if (inst[2] !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL exec_reached got inst=%h busy=%b want execute=1 busy=1", inst, busy); end
        reset = 1'b0;
        #1;
        checks++; if (inst !== IDLE_W) begin errors++; $display("FAIL midreset_inst got %h want %h", inst, IDLE_W); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL no_resume got %0d active cycles want 0", bad); end
        ofifo_valid = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        run_tile(int'($urandom_range(0, 2047)), 2045, 2046, 6, 2, 1'b1);

`ifdef INST_SEQ_ABORT_EN
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; w_base = 11'h010; act_base = 11'h020; psum_base = 11'h030; n_act = 11'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (26) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (inst !== IDLE_W) begin errors++; $display("FAIL abort_inst got %h want %h", inst, IDLE_W); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", bad); end
        mon_en = 1'b1;
        run_tile(11'h010, 11'h020, 11'h030, 4, 0, 1'b0);
`endif

        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 12));
            run_tile(int'($urandom_range(0, 2047)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(2040, 2047)) : int'($urandom_range(0, 2047)),
                     int'($urandom_range(2040, 2047)), n, 2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
